// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable serial pattern detector.
// Shifts valid input bits into a history register and compares the youngest
// len bits against the programmed pattern. It supports overlapping and
// non-overlapping matching and keeps a saturating count of matches.
module seq_detector_prog #(
  parameter int                     PATTERN_W       = 8,
  parameter int                     CNT_W           = 8,
  parameter logic [PATTERN_W-1:0]   DEFAULT_PATTERN = 8'b0000_1010,
  parameter int                     DEFAULT_LEN     = 4,
  parameter bit                     DEFAULT_OVERLAP = 1'b1,
  localparam int                    LEN_W           = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 cnt_clr,
  output logic                 z,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat,
  output logic                 cfg_err
);

  // Mask selecting the low len bits of a pattern-wide vector.
  function automatic logic [PATTERN_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PATTERN_W-1:0] m;
    for (int i = 0; i < PATTERN_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  logic [PATTERN_W-1:0] pattern_r, pattern_nxt;
  logic [LEN_W-1:0]     len_r, len_nxt;
  logic                 overlap_r, overlap_nxt;
  logic [PATTERN_W-1:0] history_r, history_nxt;
  logic [LEN_W-1:0]     hist_cnt_r, hist_cnt_nxt;
  logic                 z_r, z_nxt;
  logic                 cfg_err_r, cfg_err_nxt;
  logic [CNT_W-1:0]     match_cnt_r, match_cnt_nxt;

  logic [PATTERN_W-1:0] shifted;
  logic [LEN_W:0]       cnt_plus;
  logic                 cfg_ok;
  logic                 match;

  // Next-state logic: config load takes priority over incoming bits.
  always_comb begin
    shifted      = {history_r[PATTERN_W-2:0], x};
    cnt_plus     = {1'b0, hist_cnt_r} + {{LEN_W{1'b0}}, 1'b1};
    cfg_ok       = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(PATTERN_W));
    match        = 1'b0;
    pattern_nxt  = pattern_r;
    len_nxt      = len_r;
    overlap_nxt  = overlap_r;
    history_nxt  = history_r;
    hist_cnt_nxt = hist_cnt_r;
    z_nxt        = 1'b0;
    cfg_err_nxt  = 1'b0;

    if (cfg_load) begin
      // The bit presented in a load cycle is discarded either way.
      if (cfg_ok) begin
        pattern_nxt  = cfg_pattern;
        len_nxt      = cfg_len;
        overlap_nxt  = cfg_overlap;
        hist_cnt_nxt = {LEN_W{1'b0}};
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end else if (x_valid) begin
      match = (cnt_plus >= {1'b0, len_r}) &&
              (((shifted ^ pattern_r) & len_mask(len_r)) == {PATTERN_W{1'b0}});
      history_nxt = shifted;
      z_nxt       = match;
      // Non-overlapping mode forgets history consumed by a match.
      if (match && !overlap_r) begin
        hist_cnt_nxt = {LEN_W{1'b0}};
      end else if (hist_cnt_r == LEN_W'(PATTERN_W)) begin
        hist_cnt_nxt = hist_cnt_r;
      end else begin
        hist_cnt_nxt = cnt_plus[LEN_W-1:0];
      end
    end else begin
      history_nxt  = history_r;
      hist_cnt_nxt = hist_cnt_r;
    end

    // A clear coinciding with a match counts that match.
    if (cnt_clr) begin
      match_cnt_nxt = match ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (match && !(&match_cnt_r)) begin
      match_cnt_nxt = match_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      match_cnt_nxt = match_cnt_r;
    end
  end

  // State and output registers with asynchronous reset to the default config.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_r   <= DEFAULT_PATTERN;
      len_r       <= LEN_W'(DEFAULT_LEN);
      overlap_r   <= DEFAULT_OVERLAP;
      history_r   <= {PATTERN_W{1'b0}};
      hist_cnt_r  <= {LEN_W{1'b0}};
      z_r         <= 1'b0;
      cfg_err_r   <= 1'b0;
      match_cnt_r <= {CNT_W{1'b0}};
    end else begin
      pattern_r   <= pattern_nxt;
      len_r       <= len_nxt;
      overlap_r   <= overlap_nxt;
      history_r   <= history_nxt;
      hist_cnt_r  <= hist_cnt_nxt;
      z_r         <= z_nxt;
      cfg_err_r   <= cfg_err_nxt;
      match_cnt_r <= match_cnt_nxt;
    end
  end

  assign z         = z_r;
  assign cfg_err   = cfg_err_r;
  assign match_cnt = match_cnt_r;
  assign cnt_sat   = &match_cnt_r;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed testbench for seq_detector_prog. A second instance with a
// 2-bit counter exercises match counter saturation.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h0A;
  logic [3:0] cfg_len = 4'd4;
  logic       cfg_overlap = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       z, cnt_sat, cfg_err;
  logic [7:0] match_cnt;
  logic       z2, cnt_sat2, cfg_err2;
  logic [1:0] match_cnt2;

  int tests = 0;
  int fails = 0;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err)
  );

  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge; return just after the rising edge.
  task automatic step(input logic b, input logic v, input logic ld, input logic clr);
    @(negedge clk);
    x = b; x_valid = v; cfg_load = ld; cnt_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_z(input string name, input int idx, input logic exp);
    tests++;
    if (z !== exp) begin
      fails++;
      $display("FAIL %s bit %0d: z got %b expected %b", name, idx, z, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({z, match_cnt, cnt_sat, cfg_err, z2, match_cnt2, cnt_sat2, cfg_err2} !== 15'd0) begin
      fails++;
      $display("FAIL %s: outputs z=%b cnt=%0d sat=%b err=%b z2=%b cnt2=%0d sat2=%b err2=%b expected all 0",
               name, z, match_cnt, cnt_sat, cfg_err, z2, match_cnt2, cnt_sat2, cfg_err2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_overlap();
    logic [14:0] stream, expz;
    stream = 15'b110101011101010;
    expz   = 15'b000010100000101;
    for (int i = 0; i < 15; i++) begin
      step(stream[14-i], 1'b1, 1'b0, 1'b0);
      check_z("overlap", i + 1, expz[14-i]);
    end
    tests++;
    if (match_cnt !== 8'd4) begin
      fails++;
      $display("FAIL overlap_cnt: got %0d expected 4", match_cnt);
    end
  endtask

  task automatic test_non_overlap();
    logic [14:0] stream, expz;
    stream = 15'b110101011101010;
    expz   = 15'b000010000000100;
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (match_cnt !== 8'd0) begin
      fails++;
      $display("FAIL cnt_clr_alone: got %0d expected 0", match_cnt);
    end
    for (int i = 0; i < 15; i++) begin
      step(stream[14-i], 1'b1, 1'b0, 1'b0);
      check_z("non_overlap", i + 1, expz[14-i]);
    end
    tests++;
    if (match_cnt !== 8'd2) begin
      fails++;
      $display("FAIL non_overlap_cnt: got %0d expected 2", match_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1010;
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, 1'b0, 1'b0);
      check_z("gaps_bit", i + 1, (i == 3) ? 1'b1 : 1'b0);
      for (int g = 0; g < 3; g++) begin
        step(~bits[3-i], 1'b0, 1'b0, 1'b0);
        check_z("gaps_idle", i + 1, 1'b0);
      end
    end
  endtask

  task automatic test_cfg();
    logic [13:0] stream, expz;
    logic [5:0]  tail;
    logic [4:0]  post, postz;
    stream = 14'b11000111000111;
    expz   = 14'b00000001000001;
    tail   = 6'b000111;
    post   = 5'b01010;
    postz  = 5'b00001;
    cfg_pattern = 8'b1100_0111; cfg_len = 4'd8; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(stream[13-i], 1'b1, 1'b0, 1'b0);
      check_z("len8", i + 1, expz[13-i]);
    end
    // Rejected load: length 0.
    cfg_pattern = 8'h0A; cfg_len = 4'd0; cfg_overlap = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (cfg_err !== 1'b1 || z !== 1'b0) begin
      fails++;
      $display("FAIL cfg_err_pulse: err=%b z=%b expected err=1 z=0", cfg_err, z);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (cfg_err !== 1'b0) begin
      fails++;
      $display("FAIL cfg_err_one_cycle: got %b expected 0", cfg_err);
    end
    // Old config and history must still be in force.
    for (int i = 0; i < 6; i++) begin
      step(tail[5-i], 1'b1, 1'b0, 1'b0);
      check_z("cfg_unchanged", i + 1, (i == 5) ? 1'b1 : 1'b0);
    end
    // Accepted load with a valid bit present: bit dropped, history count cleared.
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tests++;
    if (cfg_err !== 1'b0 || z !== 1'b0) begin
      fails++;
      $display("FAIL load_accept: err=%b z=%b expected 0 0", cfg_err, z);
    end
    for (int i = 0; i < 5; i++) begin
      step(post[4-i], 1'b1, 1'b0, 1'b0);
      check_z("load_drop", i + 1, postz[4-i]);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    tests++;
    if (match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0) begin
      fails++;
      $display("FAIL sat_clear: cnt=%0d sat=%b expected 0 0", match_cnt2, cnt_sat2);
    end
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
      if (i >= 3 && (i % 2 == 1)) begin
        tests++;
        if (match_cnt2 !== exp_cnt[(i-3)/2] || cnt_sat2 !== (exp_cnt[(i-3)/2] == 2'd3)) begin
          fails++;
          $display("FAIL sat_match %0d: cnt=%0d sat=%b expected cnt=%0d", (i-3)/2 + 1,
                   match_cnt2, cnt_sat2, exp_cnt[(i-3)/2]);
        end
      end
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    tests++;
    if (z2 !== 1'b1 || match_cnt2 !== 2'd1 || cnt_sat2 !== 1'b0) begin
      fails++;
      $display("FAIL clr_with_match: z=%b cnt=%0d sat=%b expected 1 1 0", z2, match_cnt2, cnt_sat2);
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] bits;
    bits = 4'b1010;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    x_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset_async");
    @(posedge clk);
    #1;
    check_all_zero("mid_reset_held");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_z("after_reset_0", 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(bits[3-i], 1'b1, 1'b0, 1'b0);
      check_z("after_reset", i + 1, (i == 3) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps();
    test_cfg();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
